// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared widths and state encodings for the burst summer
package sum_accumulator_pkg;

  localparam int DATA_W = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - purely combinational DATA_W-bit ripple-carry adder
module ripple_carry_adder
  import sum_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  logic ripple;

  // The carry is kept in one blocking variable so the chain is not a self-loop on a vector.
  always_comb begin
    ripple = 1'b0;
    sum    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ ripple;
      ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
    end
    carry = ripple;
  end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - sums BURST_LEN operands modulo 8 with a sticky carry flag
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [DATA_W-1:0] out_count
);

  localparam logic [DATA_W-1:0] LAST_COUNT = DATA_W'(BURST_LEN - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] count;
  logic              ovf;
  logic [DATA_W-1:0] add_sum;
  logic              add_carry;
  logic              accept;

  ripple_carry_adder u_adder (
    .a     (acc),
    .b     (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (clear) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= add_sum;
            ovf   <= ovf | add_carry;
            count <= count + 1'b1;
            state <= (count == LAST_COUNT) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          acc   <= '0;
          ovf   <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed table and sequence checks for sum_accumulator
module tb_sum_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, clear, out_valid, out_ready, out_ovf;
  logic [2:0] in_data, out_sum, out_count;
  logic       in_valid1, in_ready1, clear1, out_valid1, out_ready1, out_ovf1;
  logic [2:0] in_data1, out_sum1, out_count1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [2:0] op0, op1, op2, op3;
    logic [2:0] exp_sum;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [7];

  sum_accumulator #(.BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  sum_accumulator #(.BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .clear(clear1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_ovf(out_ovf1), .out_count(out_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic push(input logic [2:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 3'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd7, 1'b0};
    vecs[1] = '{3'd7, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1};
    vecs[2] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 1'b1};
    vecs[3] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0};
    vecs[4] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd4, 1'b1};
    vecs[5] = '{3'd3, 3'd5, 3'd0, 3'd1, 3'd1, 1'b1};
    vecs[6] = '{3'd4, 3'd3, 3'd0, 3'd0, 3'd7, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 3'd0; clear = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = 3'd0; clear1 = 1'b0; out_ready1 = 1'b1;

    // Reset state holds across clock edges.
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", out_count, 0);
    check("rst_sum", out_sum, 0);
    check("rst_ovf", out_ovf, 0);
    rst = 1'b0;

    // Table: full bursts with out_ready=1, operand accepted on the first edge after reset.
    for (int v = 0; v < 7; v++) begin
      push(vecs[v].op0);
      check($sformatf("v%0d_count1", v), out_count, 1);
      check($sformatf("v%0d_valid_mid", v), out_valid, 0);
      push(vecs[v].op1);
      push(vecs[v].op2);
      push(vecs[v].op3);
      check($sformatf("v%0d_valid", v), out_valid, 1);
      check($sformatf("v%0d_in_ready", v), in_ready, 0);
      check($sformatf("v%0d_sum", v), out_sum, vecs[v].exp_sum);
      check($sformatf("v%0d_ovf", v), out_ovf, vecs[v].exp_ovf);
      check($sformatf("v%0d_count", v), out_count, 4);
      idle(1);
      check($sformatf("v%0d_idle_valid", v), out_valid, 0);
      check($sformatf("v%0d_idle_count", v), out_count, 0);
    end

    // Sticky overflow with in_valid gaps during ACCUM.
    push(3'd7);
    idle(2);
    check("gap_count", out_count, 1);
    check("gap_sum", out_sum, 7);
    push(3'd1);
    check("sticky_ovf1", out_ovf, 1);
    check("sticky_sum1", out_sum, 0);
    push(3'd0);
    check("sticky_ovf2", out_ovf, 1);
    idle(1);
    push(3'd0);
    check("sticky_valid", out_valid, 1);
    check("sticky_ovf3", out_ovf, 1);
    idle(1);

    // Backpressure: result held stable, operands refused.
    out_ready = 1'b0;
    push(3'd2); push(3'd2); push(3'd2); push(3'd2);
    in_valid = 1'b1; in_data = 3'd5;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_valid", c), out_valid, 1);
      check($sformatf("hold%0d_in_ready", c), in_ready, 0);
      check($sformatf("hold%0d_sum", c), out_sum, 0);
      check($sformatf("hold%0d_ovf", c), out_ovf, 1);
      check($sformatf("hold%0d_count", c), out_count, 4);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", out_valid, 0);
    check("hold_release_in_ready", in_ready, 1);
    check("hold_release_count", out_count, 0);

    // Clear beats a simultaneous accept.
    push(3'd3); push(3'd3);
    in_valid = 1'b1; in_data = 3'd3; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    check("clr_count", out_count, 0);
    check("clr_sum", out_sum, 0);
    check("clr_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 1);
    push(3'd1); push(3'd1); push(3'd1); push(3'd1);
    check("clr_next_valid", out_valid, 1);
    check("clr_next_sum", out_sum, 4);
    check("clr_next_ovf", out_ovf, 0);
    idle(1);

    // Clear in HOLD beats the output handshake and drops the result.
    out_ready = 1'b0;
    push(3'd7); push(3'd7); push(3'd1); push(3'd1);
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_hold_valid", out_valid, 0);
    check("clr_hold_ovf", out_ovf, 0);
    check("clr_hold_sum", out_sum, 0);

    // Asynchronous reset mid-burst.
    push(3'd1); push(3'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_mid_count", out_count, 0);
    check("arst_mid_sum", out_sum, 0);
    check("arst_mid_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    idle(3);
    check("arst_mid_after_valid", out_valid, 0);

    // Asynchronous reset in HOLD.
    out_ready = 1'b0;
    push(3'd4); push(3'd4); push(3'd1); push(3'd1);
    check("arst_hold_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_hold_valid", out_valid, 0);
    check("arst_hold_ovf", out_ovf, 0);
    check("arst_hold_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    idle(3);
    check("arst_hold_after_valid", out_valid, 0);
    push(3'd1); push(3'd1); push(3'd1);
    check("arst_partial_valid", out_valid, 0);
    push(3'd1);
    check("arst_new_valid", out_valid, 1);
    check("arst_new_sum", out_sum, 4);
    out_ready = 1'b1;
    idle(1);

    // BURST_LEN=1 goes straight to HOLD.
    check("bl1_idle_valid", out_valid1, 0);
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 3'd5;
    @(negedge clk);
    in_valid1 = 1'b0;
    check("bl1_valid", out_valid1, 1);
    check("bl1_sum", out_sum1, 5);
    check("bl1_count", out_count1, 1);
    check("bl1_ovf", out_ovf1, 0);
    check("bl1_in_ready", in_ready1, 0);
    out_ready1 = 1'b1;
    @(negedge clk);
    check("bl1_release_valid", out_valid1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter: BURST_LEN, default 4, number of operands summed per result; legal range 1..7.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand present on in_data.
REQ-005 Port: in_ready  output  1  block can accept an operand this cycle.
REQ-006 Port: in_data  input  3  unsigned operand.
REQ-007 Port: clear  input  1  synchronous abort of the current burst.
REQ-008 Port: out_valid  output  1  result present on out_sum, out_ovf and out_count.
REQ-009 Port: out_ready  input  1  downstream accepts the result.
REQ-010 Port: out_sum  output  3  accumulated sum, modulo 8.
REQ-011 Port: out_ovf  output  1  sticky: a carry-out occurred during this burst.
REQ-012 Port: out_count  output  3  operands accepted in the current burst.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE (acc=0, count=0), ACCUM (burst in progress) and HOLD (result presented).
REQ-014 An operand SHALL be accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-016 On accept, the block SHALL set acc <= (acc + in_data) mod 8 and ovf <= ovf | carry_out of that add, and SHALL increment count by 1.
REQ-017 The first accept in IDLE SHALL move the FSM to ACCUM, or directly to HOLD when BURST_LEN=1.
REQ-018 The accept that brings count to BURST_LEN SHALL move the FSM to HOLD; out_valid SHALL be 1 from the next cycle (latency 1 cycle after the last accept).
REQ-019 In HOLD, out_sum, out_ovf and out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 In HOLD with out_ready=1, the block SHALL return to IDLE with acc, ovf and count cleared; the next operand is accepted no earlier than the following cycle.
REQ-021 out_valid SHALL be 0 in IDLE and ACCUM; out_sum, out_ovf and out_count SHALL reflect the live registers in every state.
REQ-022 clear=1 SHALL force IDLE with acc, ovf and count cleared on the next edge, in any state; it takes priority over a simultaneous accept or output handshake, and the operand offered in that cycle is discarded.
REQ-023 in_valid=0 during ACCUM SHALL leave all state unchanged; there is no timeout.
REQ-024 Zero-valued operands SHALL count toward BURST_LEN.

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE with acc=0, ovf=0, count=0, out_valid=0 and in_ready=1, independent of clk.
REQ-026 Reset asserted mid-burst or in HOLD SHALL discard the partial or pending result, with no output handshake.
REQ-027 After rst deasserts, the first operand SHALL be acceptable on the first rising clk edge.

Structure
REQ-028 A shared package SHALL hold the state-encoding constants (IDLE, ACCUM, HOLD) and DATA_W=3.
REQ-029 The add SHALL be performed by one instance of the team's 3-bit ripple_carry_adder sub-module, operands acc and in_data; its carry output feeds ovf.
REQ-030 All registers SHALL reside in sum_accumulator; the adder instance SHALL remain purely combinational.

Verification
REQ-031 Operands 1, 2, 3, 1 with BURST_LEN=4 and out_ready=1 -> one out_valid pulse with out_sum=7, out_ovf=0, out_count=4.
REQ-032 Operands 7, 1, 0, 0 -> out_sum=0, out_ovf=1, out_count=4; out_ovf stays 1 for the rest of the burst.
REQ-033 Burst 2, 2, 2, 2 with out_ready=0 for 5 cycles -> out_valid held 5 cycles with out_sum=0 and out_ovf=1 stable, in_ready=0 throughout; out_ready=1 -> IDLE the next cycle.
REQ-034 clear asserted with in_valid=1 after 2 accepts (operands 3, 3) -> next cycle count=0, acc=0, FSM in IDLE, no out_valid; a following burst 1, 1, 1, 1 yields out_sum=4.
REQ-035 rst pulsed asynchronously mid-burst and again in HOLD -> outputs return to reset values immediately; no out_valid appears afterwards until a full new burst is accepted.
REQ-036 BURST_LEN=1 with operand 5 -> out_valid on the next cycle with out_sum=5, out_count=1.
